// File: rtl/mealy_estado_sig.sv
// State register and next-state logic of the overlapping "1101" Mealy detector, plus a
// saturating detection counter. Define MEALY_SYNC_EN to pass w through a two-flop synchronizer.
module mealy_estado_sig #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic             clr_cnt,
  output logic             w_q,
  output logic             y1,
  output logic             y2,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    S0 = 2'b00,  // nothing matched
    S1 = 2'b01,  // "1"
    S2 = 2'b10,  // "11"
    S3 = 2'b11   // "110"
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   detect;

`ifdef MEALY_SYNC_EN
  logic w_meta;

  // The synchronizer runs every edge, independent of en, so w_q always tracks w two edges late.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_meta <= 1'b0;
      w_q    <= 1'b0;
    end else begin
      w_meta <= w;
      w_q    <= w_meta;
    end
  end
`else
  assign w_q = w;
`endif

  // Same condition the downstream stage uses for z = w_q & y1 & y2.
  assign detect = en && w_q && (state == S3);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
      cnt   <= '0;
    end else begin
      if (en) begin
        unique case (state)
          S0: state <= w_q ? S1 : S0;
          S1: state <= w_q ? S2 : S0;
          S2: state <= w_q ? S2 : S3;
          S3: state <= w_q ? S1 : S0;  // trailing "1" of a match starts the next one
        endcase
      end
      if (clr_cnt)
        cnt <= '0;
      else if (detect && (cnt != CNT_MAX))
        cnt <= cnt + 1'b1;
    end
  end

  assign {y1, y2} = state;

endmodule

// File: tb/tb_mealy_estado_sig.sv
// Self-checking bench for mealy_estado_sig: suffix-matching reference model checked every
// cycle on a CNT_W=2 and a default-width instance, plus hand-computed directed expectations.
module tb_mealy_estado_sig;

  logic       clk = 1'b0;
  logic       reset, en, w, clr_cnt;
  logic       w_q, y1, y2;
  logic [1:0] cnt2;
  logic       w_q8, y1_8, y2_8;
  logic [7:0] cnt8;

  int n_tests = 0;
  int n_fail  = 0;

  mealy_estado_sig #(.CNT_W(2)) dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .clr_cnt(clr_cnt),
    .w_q(w_q), .y1(y1), .y2(y2), .cnt(cnt2)
  );

  mealy_estado_sig dut8 (
    .clk(clk), .reset(reset), .en(en), .w(w), .clr_cnt(clr_cnt),
    .w_q(w_q8), .y1(y1_8), .y2(y2_8), .cnt(cnt8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the last four accepted bits; the state is the longest suffix that is a
  // proper prefix of "1101", and a detection is the accepted bits ending in "1101".
  logic [3:0] m_hist;
  logic [1:0] m_pipe;
  logic       m_bit;
  int         m_cnt2, m_cnt8;
  bit         m_valid = 1'b0;

  function automatic logic [1:0] m_state(input logic [3:0] h);
    if (h[2:0] == 3'b110) return 2'd3;
    if (h[1:0] == 2'b11)  return 2'd2;
    if (h[0])             return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic m_wq();
`ifdef MEALY_SYNC_EN
    return m_pipe[1];
`else
    return w;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hist  = 4'b0;
      m_pipe  = 2'b0;
      m_cnt2  = 0;
      m_cnt8  = 0;
      m_valid = 1'b1;
    end else begin
      m_bit = m_wq();
      if (en) begin
        m_hist = {m_hist[2:0], m_bit};
        if (m_hist == 4'b1101) begin
          if (m_cnt2 < 3)   m_cnt2++;
          if (m_cnt8 < 255) m_cnt8++;
        end
      end
      if (clr_cnt) begin
        m_cnt2 = 0;
        m_cnt8 = 0;
      end
      m_pipe = {m_pipe[0], w};
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_state",   {y1, y2},     m_state(m_hist));
      check("model_w_q",     w_q,          m_wq());
      check("model_cnt2",    cnt2,         m_cnt2);
      check("model_state8",  {y1_8, y2_8}, m_state(m_hist));
      check("model_w_q8",    w_q8,         m_wq());
      check("model_cnt8",    cnt8,         m_cnt8);
    end
  end

  // Apply inputs, then return 1 time unit after the edge that consumes them.
  task automatic cyc(input logic w_i, input logic en_i, input logic clr_i, input logic rst_i);
    w = w_i; en = en_i; clr_cnt = clr_i; reset = rst_i;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(bits[i], 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; w = 1'b0; clr_cnt = 1'b0;

    // Reset held two edges with w=1, en=1: nothing may advance.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_state", {y1, y2}, 2'b00);
    check("reset_cnt2",  cnt2,     2'd0);
    check("reset_cnt8",  cnt8,     8'd0);

`ifdef MEALY_SYNC_EN
    check("reset_w_q", w_q, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    // Single pulse sampled at edge k shows on w_q after k+1 and is consumed at k+2.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("sync_k_w_q",  w_q,      1'b0);
    check("sync_k_st",   {y1, y2}, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("sync_k1_w_q", w_q,      1'b1);
    check("sync_k1_st",  {y1, y2}, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("sync_k2_w_q", w_q,      1'b0);
    check("sync_k2_st",  {y1, y2}, 2'b01);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("sync_k3_st",  {y1, y2}, 2'b00);
    // Reset while a pulse is in flight must flush it.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("sync_rst_w_q", w_q,      1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("sync_flush_w_q", w_q,    1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("sync_flush_st", {y1, y2}, 2'b00);
    // Overlapping stream driven two edges early; model checks each cycle.
    feed(16'b1101101_000, 10);
    check("sync_overlap_cnt8", cnt8, 8'd2);
`else
    // Basic detect.
    cyc(1'b1, 1'b1, 1'b0, 1'b0); check("basic_s1", {y1, y2}, 2'b01);
    cyc(1'b1, 1'b1, 1'b0, 1'b0); check("basic_s2", {y1, y2}, 2'b10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0); check("basic_s3", {y1, y2}, 2'b11);
    check("basic_pre_cnt", cnt8, 8'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0); check("basic_det_st", {y1, y2}, 2'b01);
    check("basic_det_cnt", cnt8, 8'd1);

    // Overlap: 1101101 gives two detections; 11101 gives one.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    feed(16'b1101101, 7);
    check("ovl_cnt2", cnt2, 2'd2);
    check("ovl_cnt8", cnt8, 8'd2);
    check("ovl_st",   {y1, y2}, 2'b01);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    feed(16'b1110, 4);
    check("rep1_s3",  {y1, y2}, 2'b11);
    feed(16'b1, 1);
    check("rep1_cnt8", cnt8, 8'd1);

    // Enable gating: hold S3 for five edges while w toggles.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    feed(16'b110, 3);
    for (int i = 0; i < 5; i++) cyc(i[0], 1'b0, 1'b0, 1'b0);
    check("gate_hold_st",  {y1, y2}, 2'b11);
    check("gate_hold_cnt", cnt8, 8'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("gate_det_st",  {y1, y2}, 2'b01);
    check("gate_det_cnt", cnt8, 8'd1);

    // Saturation: five overlapping detections; 2-bit counter stops at 3.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    feed(16'b1101101101101101, 16);
    check("sat_cnt2", cnt2, 2'd3);
    check("sat_cnt8", cnt8, 8'd5);
    // Clear wins over a simultaneous detection; FSM still moves to S1.
    feed(16'b10, 2);
    check("clr_pre_st", {y1, y2}, 2'b11);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_cnt2", cnt2, 2'd0);
    check("clr_cnt8", cnt8, 8'd0);
    check("clr_st",   {y1, y2}, 2'b01);

    // Mid-sequence reset discards the partial "11".
    feed(16'b1, 1);
    check("mid_pre_st", {y1, y2}, 2'b10);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("mid_rst_st", {y1, y2}, 2'b00);
    feed(16'b101, 3);
    check("mid_post_st",  {y1, y2}, 2'b01);
    check("mid_post_cnt", cnt8, 8'd0);
`endif

    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
